// File: rtl/vram_write_queue_pkg.sv
// Shared constants and drain FSM encoding for the back-VRAM write queue.
package vram_write_queue_pkg;

    localparam logic [15:0] VRAM_BASE   = 16'h8000;
    localparam logic [15:0] CTRL_ADDR   = 16'hA000;
    localparam int          VRAM_ADDR_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } drain_state_t;

endpackage

// File: rtl/vram_write_queue_if.sv
// Z80 write bus on one side and back-VRAM SRAM pins on the other.
interface vram_write_queue_if;
    import vram_write_queue_pkg::*;

    logic [15:0]            cpu_addr;
    logic [7:0]             cpu_data_in;
    logic                   cpu_wr;
    logic                   cpu_mreq;
    logic [VRAM_ADDR_W-1:0] back_vram_addr;
    logic [7:0]             back_vram_data_out;
    logic                   back_vram_data_oe;
    logic                   back_vram_wr_low;

    modport master (
        output cpu_addr, cpu_data_in, cpu_wr, cpu_mreq,
        input  back_vram_addr, back_vram_data_out, back_vram_data_oe, back_vram_wr_low
    );

    modport slave (
        input  cpu_addr, cpu_data_in, cpu_wr, cpu_mreq,
        output back_vram_addr, back_vram_data_out, back_vram_data_oe, back_vram_wr_low
    );

endinterface

// File: rtl/vram_write_queue_sync_fifo.sv
// Generic synchronous FIFO; pop_data is a register that holds the last popped entry.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Level never exceeds DEPTH, so its MSB alone marks the full state.
    assign full    = level[DEPTH_LOG2];
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            pop_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pop_data <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/vram_write_queue.sv
// Captures Z80 writes into the back-VRAM window, queues them and drains them to SRAM
// with a timed WE_n strobe, deferring to the buffer copier between cycles.
module vram_write_queue #(
    parameter logic [15:0] VRAM_BASE       = vram_write_queue_pkg::VRAM_BASE,
    parameter logic [15:0] CTRL_ADDR       = vram_write_queue_pkg::CTRL_ADDR,
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter int          WR_PULSE        = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vram_write_queue_if.slave        bus,
    input  logic                     copy_in_progress,
    output logic                     back_vram_busy,
    output logic [7:0]               copy_enable,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     fifo_overflow
);
    import vram_write_queue_pkg::*;

    localparam int          ENTRY_W    = VRAM_ADDR_W + 8;
    localparam logic [2:0]  PULSE_LAST = 3'(WR_PULSE - 1);

    logic [1:0]         rst_sync;
    logic               rst_int_n;
    logic               strobe_n, strobe_meta, strobe_sync, strobe_prev, strobe_fall;
    logic [15:0]        addr_p1, addr_p2;
    logic [7:0]         data_p1, data_p2;
    logic               push_req;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_full, fifo_empty, fifo_pop;
    drain_state_t       state, state_next;
    logic [2:0]         pulse_cnt;
    logic               wr_low_q, oe_q;

    // Reset asserts at once but releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign strobe_n    = bus.cpu_wr | bus.cpu_mreq;
    assign strobe_fall = strobe_prev & ~strobe_sync;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            strobe_meta <= 1'b1;
            strobe_sync <= 1'b1;
            strobe_prev <= 1'b1;
            addr_p1     <= '0;
            addr_p2     <= '0;
            data_p1     <= '0;
            data_p2     <= '0;
        end else begin
            strobe_meta <= strobe_n;
            strobe_sync <= strobe_meta;
            strobe_prev <= strobe_sync;
            addr_p1     <= bus.cpu_addr;
            addr_p2     <= addr_p1;
            data_p1     <= bus.cpu_data_in;
            data_p2     <= data_p1;
        end
    end

    // Address decode fires once per synchronized strobe fall.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            push_req    <= 1'b0;
            push_entry  <= '0;
            copy_enable <= '0;
        end else begin
            push_req   <= strobe_fall &&
                          (addr_p2[15:VRAM_ADDR_W] == VRAM_BASE[15:VRAM_ADDR_W]);
            push_entry <= {addr_p2[VRAM_ADDR_W-1:0], data_p2};
            if (strobe_fall && (addr_p2 == CTRL_ADDR)) begin
                copy_enable <= data_p2;
            end
        end
    end

    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)                                fifo_overflow <= 1'b0;
        else if (push_req && fifo_full && !fifo_pop)   fifo_overflow <= 1'b1;
    end

    // Strobe outputs are registered from the next state so WE_n is glitch-free.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state          <= ST_IDLE;
            pulse_cnt      <= '0;
            wr_low_q       <= 1'b1;
            oe_q           <= 1'b0;
            back_vram_busy <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == ST_STROBE && state != ST_STROBE) begin
                pulse_cnt <= PULSE_LAST;
            end else if (state == ST_STROBE) begin
                pulse_cnt <= pulse_cnt - 3'd1;
            end
            wr_low_q       <= (state_next != ST_STROBE);
            oe_q           <= (state_next != ST_IDLE);
            back_vram_busy <= (state_next != ST_IDLE);
        end
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !copy_in_progress) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP:  state_next = ST_STROBE;
            ST_STROBE: if (pulse_cnt == 3'd0) state_next = ST_HOLD;
            ST_HOLD:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign bus.back_vram_addr     = fifo_head[ENTRY_W-1:8];
    assign bus.back_vram_data_out = fifo_head[7:0];
    assign bus.back_vram_data_oe  = oe_q;
    assign bus.back_vram_wr_low   = wr_low_q;

endmodule

// File: tb/tb_vram_write_queue.sv
// Scoreboard bench: stimulus pushes expected SRAM writes, a negedge monitor checks every cycle.
module tb_vram_write_queue;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int WR_PULSE   = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                copy_in_progress = 1'b0;
    logic                back_vram_busy;
    logic [7:0]          copy_enable;
    logic [DEPTH_LOG2:0] fifo_level;
    logic                fifo_overflow;

    vram_write_queue_if bus ();

    vram_write_queue #(
        .VRAM_BASE       (16'h8000),
        .CTRL_ADDR       (16'hA000),
        .FIFO_DEPTH_LOG2 (DEPTH_LOG2),
        .WR_PULSE        (WR_PULSE)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .copy_in_progress (copy_in_progress),
        .back_vram_busy   (back_vram_busy),
        .copy_enable      (copy_enable),
        .fifo_level       (fifo_level),
        .fifo_overflow    (fifo_overflow)
    );

    always #10 clk = ~clk;

    int          testsRun = 0;
    int          testsFailed = 0;
    logic [20:0] expQ [$];
    logic [7:0]  expCopyEnable = 8'h00;
    bit          expOverflow = 1'b0;
    int          blockedPending = 0;
    int          sramCycles = 0;
    int          lowCnt = 0;
    logic        prevWrLow = 1'b1;
    logic [20:0] monEntry;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: window 0x8000..0x9FFF queues, 0xA000 sets the register,
    // and a blocked queue keeps only the first DEPTH writes.
    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data,
                                 input int holdClk, input bit isWrite, input int gapClk);
        logic [15:0] off;
        if (isWrite) begin
            if (addr >= 16'h8000 && addr < 16'hA000) begin
                if (copy_in_progress && blockedPending >= DEPTH) begin
                    expOverflow = 1'b1;
                end else begin
                    off = addr - 16'h8000;
                    expQ.push_back({off[12:0], data});
                    if (copy_in_progress) blockedPending++;
                end
            end else if (addr == 16'hA000) begin
                expCopyEnable = data;
            end
        end
        bus.cpu_addr    = addr;
        bus.cpu_data_in = data;
        bus.cpu_mreq    = 1'b0;
        bus.cpu_wr      = !isWrite;
        repeat (holdClk) @(negedge clk);
        bus.cpu_mreq = 1'b1;
        bus.cpu_wr   = 1'b1;
        repeat (gapClk) @(negedge clk);
    endtask

    task automatic waitDrained(input int budget);
        int n = 0;
        while (n < budget && !(expQ.size() == 0 && !back_vram_busy && fifo_level == 0)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_within_budget", 32'(n < budget), 1);
    endtask

    task automatic waitStrobeLow(input int budget);
        int n = 0;
        while (n < budget && bus.back_vram_wr_low) begin
            @(negedge clk);
            n++;
        end
        checkOutput("strobe_seen", 32'(bus.back_vram_wr_low), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prevWrLow = 1'b1;
            lowCnt    = 0;
        end else begin
            if (prevWrLow && !bus.back_vram_wr_low) begin
                sramCycles++;
                lowCnt = 1;
                checkOutput("sram_cycle_expected", 32'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    monEntry = expQ.pop_front();
                    checkOutput("sram_addr", 32'(bus.back_vram_addr), 32'(monEntry[20:8]));
                    checkOutput("sram_data", 32'(bus.back_vram_data_out), 32'(monEntry[7:0]));
                end
                checkOutput("oe_during_strobe", 32'(bus.back_vram_data_oe), 1);
            end else if (!bus.back_vram_wr_low) begin
                lowCnt++;
            end else if (!prevWrLow) begin
                checkOutput("strobe_width", lowCnt, WR_PULSE);
            end
            prevWrLow = bus.back_vram_wr_low;
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          cyc, maxLvl, cycBase, kind, n;
        logic [15:0] a;

        bus.cpu_addr    = '0;
        bus.cpu_data_in = '0;
        bus.cpu_wr      = 1'b1;
        bus.cpu_mreq    = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_wr_low", 32'(bus.back_vram_wr_low), 1);
        checkOutput("rst_oe", 32'(bus.back_vram_data_oe), 0);
        checkOutput("rst_addr", 32'(bus.back_vram_addr), 0);
        checkOutput("rst_data", 32'(bus.back_vram_data_out), 0);
        checkOutput("rst_busy", 32'(back_vram_busy), 0);
        checkOutput("rst_copy_enable", 32'(copy_enable), 0);
        checkOutput("rst_level", 32'(fifo_level), 0);
        checkOutput("rst_overflow", 32'(fifo_overflow), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        cycBase = sramCycles;
        maxLvl  = 0;
        cyc     = 0;
        fork
            applyStimulus(16'h8123, 8'h5A, 6, 1'b1, 4);
            begin
                while (cyc < 40) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (int'(fifo_level) > maxLvl) maxLvl = int'(fifo_level);
                    if (!bus.back_vram_wr_low) break;
                end
            end
        join
        checkOutput("write_latency", cyc, 6);
        checkOutput("level_peak", maxLvl, 1);
        waitDrained(100);
        checkOutput("single_cycle", sramCycles - cycBase, 1);

        cycBase = sramCycles;
        applyStimulus(16'hA000, 8'h03, 5, 1'b1, 5);
        checkOutput("copy_enable_write", 32'(copy_enable), 32'(expCopyEnable));
        applyStimulus(16'h4000, 8'hC3, 5, 1'b1, 5);
        repeat (10) @(negedge clk);
        checkOutput("no_sram_for_ctrl_or_other", sramCycles - cycBase, 0);
        checkOutput("level_after_ctrl", 32'(fifo_level), 0);

        copy_in_progress = 1'b1;
        blockedPending   = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(16'h8000 | 16'($urandom & 32'h1FFF), 8'($urandom), 4, 1'b1, 4);
        end
        repeat (6) @(negedge clk);
        checkOutput("level_full", 32'(fifo_level), 32'(blockedPending));
        checkOutput("overflow_set", 32'(fifo_overflow), 32'(expOverflow));
        cycBase          = sramCycles;
        copy_in_progress = 1'b0;
        blockedPending   = 0;
        waitDrained(400);
        checkOutput("drained_count", sramCycles - cycBase, DEPTH);
        checkOutput("overflow_sticky", 32'(fifo_overflow), 32'(expOverflow));

        copy_in_progress = 1'b1;
        applyStimulus(16'h8111, 8'hA1, 4, 1'b1, 4);
        applyStimulus(16'h8222, 8'hB2, 4, 1'b1, 4);
        cycBase          = sramCycles;
        copy_in_progress = 1'b0;
        blockedPending   = 0;
        waitStrobeLow(60);
        copy_in_progress = 1'b1;
        n = 0;
        while (back_vram_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_until_hold_end", n, WR_PULSE + 1);
        repeat (20) @(negedge clk);
        checkOutput("deferred_level", 32'(fifo_level), 1);
        checkOutput("deferred_busy", 32'(back_vram_busy), 0);
        checkOutput("deferred_cycles", sramCycles - cycBase, 1);
        copy_in_progress = 1'b0;
        waitDrained(100);

        copy_in_progress = 1'b1;
        applyStimulus(16'hA000, 8'h07, 4, 1'b1, 4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h8300 + 16'(i), 8'(8'h40 + i), 4, 1'b1, 4);
        end
        copy_in_progress = 1'b0;
        blockedPending   = 0;
        waitStrobeLow(60);
        #5;
        rst_n = 1'b0;
        #2;
        checkOutput("async_rst_wr_low", 32'(bus.back_vram_wr_low), 1);
        checkOutput("async_rst_oe", 32'(bus.back_vram_data_oe), 0);
        checkOutput("async_rst_busy", 32'(back_vram_busy), 0);
        checkOutput("async_rst_level", 32'(fifo_level), 0);
        checkOutput("async_rst_copy_enable", 32'(copy_enable), 0);
        checkOutput("async_rst_overflow", 32'(fifo_overflow), 0);
        expQ.delete();
        expCopyEnable = 8'h00;
        expOverflow   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        cycBase = sramCycles;
        applyStimulus(16'h8ABC, 8'h11, 40, 1'b1, 6);
        waitDrained(100);
        checkOutput("long_strobe_one_push", sramCycles - cycBase, 1);
        applyStimulus(16'h8000, 8'h22, 5, 1'b1, 5);
        applyStimulus(16'h9FFF, 8'h33, 5, 1'b1, 5);
        waitDrained(100);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                applyStimulus(16'h8000 | 16'($urandom & 32'h1FFF), 8'($urandom),
                              $urandom_range(4, 8), 1'b1, $urandom_range(4, 8));
            end else if (kind == 6) begin
                applyStimulus(16'hA000, 8'($urandom), $urandom_range(4, 8), 1'b1,
                              $urandom_range(4, 8));
                checkOutput("random_copy_enable", 32'(copy_enable), 32'(expCopyEnable));
            end else if (kind == 7) begin
                a = 16'($urandom);
                if ((a >= 16'h8000 && a < 16'hA000) || a == 16'hA000) a = a ^ 16'h4000;
                applyStimulus(a, 8'($urandom), $urandom_range(4, 8), 1'b1, $urandom_range(4, 8));
            end else begin
                applyStimulus(16'h8000 | 16'($urandom & 32'h1FFF), 8'($urandom),
                              $urandom_range(4, 8), 1'b0, $urandom_range(4, 8));
            end
        end
        waitDrained(300);
        checkOutput("final_overflow", 32'(fifo_overflow), 32'(expOverflow));
        checkOutput("final_queue_empty", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
